// File: rtl/usb_trsac_pkg.sv
// Shared encodings and the handshake reply decision for the device transaction sequencer.
package usb_trsac_pkg;

    localparam logic [1:0] REQ_NONE    = 2'b00;
    localparam logic [1:0] REQ_START   = 2'b01;
    localparam logic [1:0] REQ_SUCCESS = 2'b10;
    localparam logic [1:0] REQ_FAIL    = 2'b11;

    localparam logic [1:0] TYPE_OUT   = 2'b00;
    localparam logic [1:0] TYPE_IN    = 2'b01;
    localparam logic [1:0] TYPE_SETUP = 2'b10;
    localparam logic [1:0] TYPE_RSVD  = 2'b11;

    localparam logic [1:0] REPLY_ACK   = 2'b00;
    localparam logic [1:0] REPLY_NAK   = 2'b01;
    localparam logic [1:0] REPLY_STALL = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_FLUSH   = 3'd4
    } state_e;

    // Handshake for a token. SETUP can never be refused on an implemented endpoint,
    // even a halted one, because it is how the host clears the halt.
    function automatic logic [1:0] reply_decide(input logic       ep_impl,
                                                input logic [1:0] ttype,
                                                input logic       stall,
                                                input logic       in_ready,
                                                input logic       out_space);
        logic [1:0] r;
        if (!ep_impl) begin
            r = REPLY_STALL;
        end else if (ttype == TYPE_SETUP) begin
            r = REPLY_ACK;
        end else if (stall) begin
            r = REPLY_STALL;
        end else if (ttype == TYPE_IN) begin
            r = in_ready ? REPLY_ACK : REPLY_NAK;
        end else if (ttype == TYPE_OUT) begin
            r = out_space ? REPLY_ACK : REPLY_NAK;
        end else begin
            r = REPLY_STALL;
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_trsac_ctrl.sv
// Device-side transaction sequencer: replies to core START requests, streams IN bytes from
// the application into tfifo, streams OUT/SETUP bytes from rfifo to the application, and
// reports one completion event per transaction.
module usb_trsac_ctrl
    import usb_trsac_pkg::*;
#(
    parameter int NEP = 4
) (
    input  logic           clk_4xrate,
    input  logic           rst1_sync,
    input  logic [1:0]     trsac_req,
    input  logic [3:0]     trsac_ep,
    input  logic [1:0]     trsac_type,
    output logic [1:0]     trsac_reply,
    output logic           rfifo_rd,
    input  logic           rfifo_empty,
    input  logic [7:0]     rfifo_rdata,
    output logic           tfifo_wr,
    input  logic           tfifo_full,
    output logic [7:0]     tfifo_wdata,
    input  logic [NEP-1:0] ep_stall,
    input  logic [NEP-1:0] ep_in_ready,
    input  logic [NEP-1:0] ep_out_space,
    input  logic [7:0]     tx_data,
    input  logic           tx_valid,
    input  logic           tx_last,
    input  logic           tx_zlp,
    output logic           tx_ready,
    output logic [7:0]     rx_data,
    output logic           rx_valid,
    input  logic           rx_ready,
    output logic           rx_commit,
    output logic           rx_abort,
    output logic [3:0]     cur_ep,
    output logic           ev_done,
    output logic [1:0]     ev_type,
    output logic           ev_ok
);

    state_e     state_q, state_d;
    logic [1:0] reply_q, reply_d;
    logic [3:0] cur_ep_q, cur_ep_d;
    logic [1:0] cur_type_q, cur_type_d;
    logic       succ_q, succ_d;        // core SUCCESS seen, waiting for rfifo to drain
    logic       pre_q, pre_d;          // FLUSH is clearing residue ahead of a new DRAIN
    logic       pend_q, pend_d;        // refused START whose event collided with an abort event
    logic [1:0] pend_type_q, pend_type_d;
    logic       ev_done_q, ev_done_d;
    logic       ev_ok_q, ev_ok_d;
    logic [1:0] ev_type_q, ev_type_d;
    logic       commit_q, commit_d;
    logic       abort_q, abort_d;

    logic [15:0] stall_x, in_ready_x, out_space_x;
    logic        ep_impl;
    logic [1:0]  reply_new;
    logic        busy, rx_phase, tx_last_acc;
    logic        is_start, is_succ, is_fail;

    assign stall_x     = 16'(ep_stall);
    assign in_ready_x  = 16'(ep_in_ready);
    assign out_space_x = 16'(ep_out_space);
    assign ep_impl     = (32'(trsac_ep) < NEP);
    assign reply_new   = reply_decide(ep_impl, trsac_type, stall_x[trsac_ep],
                                      in_ready_x[trsac_ep], out_space_x[trsac_ep]);

    assign is_start    = (trsac_req == REQ_START);
    assign is_succ     = (trsac_req == REQ_SUCCESS);
    assign is_fail     = (trsac_req == REQ_FAIL);
    assign busy        = (state_q != ST_IDLE);
    assign rx_phase    = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
    assign tx_last_acc = tx_valid && tx_ready && tx_last;

    // State and registered outputs; data paths are pure pass-through and need no reset.
    always_ff @(posedge clk_4xrate) begin
        if (rst1_sync) begin
            state_q     <= ST_IDLE;
            reply_q     <= REPLY_NAK;
            cur_ep_q    <= 4'd0;
            cur_type_q  <= 2'd0;
            succ_q      <= 1'b0;
            pre_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_type_q <= 2'd0;
            ev_done_q   <= 1'b0;
            ev_ok_q     <= 1'b0;
            ev_type_q   <= 2'd0;
            commit_q    <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            reply_q     <= reply_d;
            cur_ep_q    <= cur_ep_d;
            cur_type_q  <= cur_type_d;
            succ_q      <= succ_d;
            pre_q       <= pre_d;
            pend_q      <= pend_d;
            pend_type_q <= pend_type_d;
            ev_done_q   <= ev_done_d;
            ev_ok_q     <= ev_ok_d;
            ev_type_q   <= ev_type_d;
            commit_q    <= commit_d;
            abort_q     <= abort_d;
        end
    end

    // Next state, reply and completion events for the following cycle.
    always_comb begin
        state_d     = state_q;
        reply_d     = reply_q;
        cur_ep_d    = cur_ep_q;
        cur_type_d  = cur_type_q;
        succ_d      = succ_q;
        pre_d       = pre_q;
        pend_d      = 1'b0;
        pend_type_d = pend_type_q;
        ev_done_d   = 1'b0;
        ev_ok_d     = 1'b0;
        ev_type_d   = ev_type_q;
        commit_d    = 1'b0;
        abort_d     = 1'b0;

        if (pend_q) begin
            ev_done_d = 1'b1;
            ev_type_d = pend_type_q;
        end

        if (is_start) begin
            reply_d    = reply_new;
            cur_ep_d   = trsac_ep;
            cur_type_d = trsac_type;
            succ_d     = 1'b0;
            pre_d      = 1'b0;
            // A new token preempts whatever is in flight; the old one completes as failed.
            if (busy) begin
                ev_done_d = 1'b1;
                ev_type_d = cur_type_q;
                abort_d   = rx_phase;
            end
            if (reply_new == REPLY_ACK) begin
                if (trsac_type == TYPE_IN) begin
                    state_d = ST_FILL;
                end else if (rx_phase) begin
                    // Bytes of the preempted packet may still sit in rfifo.
                    state_d = ST_FLUSH;
                    pre_d   = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end else begin
                state_d = ST_IDLE;
                // Only one ev_done per cycle: defer this one if the slot is taken.
                if (busy || pend_q) begin
                    pend_d      = 1'b1;
                    pend_type_d = trsac_type;
                end else begin
                    ev_done_d = 1'b1;
                    ev_type_d = trsac_type;
                end
            end
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (is_succ || is_fail) begin
                        ev_done_d = 1'b1;
                        ev_type_d = cur_type_q;
                        state_d   = ST_IDLE;
                    end else if (tx_last_acc) begin
                        state_d = ST_WAIT_IN;
                    end
                end
                ST_WAIT_IN: begin
                    if (is_succ || is_fail) begin
                        ev_done_d = 1'b1;
                        ev_ok_d   = is_succ;
                        ev_type_d = cur_type_q;
                        state_d   = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (is_fail) begin
                        state_d = ST_FLUSH;
                        succ_d  = 1'b0;
                    end else if ((succ_q || is_succ) && rfifo_empty) begin
                        commit_d  = 1'b1;
                        ev_done_d = 1'b1;
                        ev_ok_d   = 1'b1;
                        ev_type_d = cur_type_q;
                        succ_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end else if (is_succ) begin
                        succ_d = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (pre_q && is_succ) begin
                        succ_d = 1'b1;
                    end
                    if (rfifo_empty) begin
                        pre_d = 1'b0;
                        if (pre_q && !is_fail) begin
                            state_d = ST_DRAIN;
                        end else begin
                            abort_d   = 1'b1;
                            ev_done_d = 1'b1;
                            ev_type_d = cur_type_q;
                            succ_d    = 1'b0;
                            state_d   = ST_IDLE;
                        end
                    end else if (pre_q && is_fail) begin
                        pre_d  = 1'b0;
                        succ_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stream handshakes, decoded directly from the current state.
    always_comb begin
        tx_ready = (state_q == ST_FILL) && !tfifo_full;
        tfifo_wr = tx_valid && tx_ready && !tx_zlp;
        rx_valid = (state_q == ST_DRAIN) && !rfifo_empty;
        rfifo_rd = (rx_valid && rx_ready) || ((state_q == ST_FLUSH) && !rfifo_empty);
    end

    assign tfifo_wdata = tx_data;
    assign rx_data     = rfifo_rdata;
    assign trsac_reply = reply_q;
    assign cur_ep      = cur_ep_q;
    assign ev_done     = ev_done_q;
    assign ev_ok       = ev_ok_q;
    assign ev_type     = ev_type_q;
    assign rx_commit   = commit_q;
    assign rx_abort    = abort_q;

endmodule

// File: tb/tb_usb_trsac_ctrl.sv
// Self-checking bench for usb_trsac_ctrl with queue-based rfifo/tfifo/app-stream models.
module tb_usb_trsac_ctrl;

    localparam int NEP = 4;
    localparam logic [1:0] ACK = 2'b00, NAK = 2'b01, STALL = 2'b10;
    localparam logic [1:0] R_START = 2'b01, R_SUCC = 2'b10, R_FAIL = 2'b11;
    localparam logic [1:0] T_OUT = 2'b00, T_IN = 2'b01, T_SETUP = 2'b10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     trsac_req = 2'b00;
    logic [3:0]     trsac_ep = 4'd0;
    logic [1:0]     trsac_type = 2'b00;
    logic [1:0]     trsac_reply;
    logic           rfifo_rd, rfifo_empty;
    logic [7:0]     rfifo_rdata;
    logic           tfifo_wr;
    logic           tfifo_full = 1'b0;
    logic [7:0]     tfifo_wdata;
    logic [NEP-1:0] ep_stall = '0, ep_in_ready = '0, ep_out_space = '0;
    logic [7:0]     tx_data;
    logic           tx_valid, tx_last, tx_zlp, tx_ready;
    logic [7:0]     rx_data;
    logic           rx_valid, rx_commit, rx_abort, ev_done, ev_ok;
    logic           rx_ready = 1'b0;
    logic [3:0]     cur_ep;
    logic [1:0]     ev_type;

    always #5 clk = ~clk;

    usb_trsac_ctrl #(.NEP(NEP)) dut (
        .clk_4xrate(clk), .rst1_sync(rst), .trsac_req(trsac_req), .trsac_ep(trsac_ep),
        .trsac_type(trsac_type), .trsac_reply(trsac_reply), .rfifo_rd(rfifo_rd),
        .rfifo_empty(rfifo_empty), .rfifo_rdata(rfifo_rdata), .tfifo_wr(tfifo_wr),
        .tfifo_full(tfifo_full), .tfifo_wdata(tfifo_wdata), .ep_stall(ep_stall),
        .ep_in_ready(ep_in_ready), .ep_out_space(ep_out_space), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_last(tx_last), .tx_zlp(tx_zlp), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_commit(rx_commit),
        .rx_abort(rx_abort), .cur_ep(cur_ep), .ev_done(ev_done), .ev_type(ev_type), .ev_ok(ev_ok)
    );

    int checks = 0, errors = 0;
    logic [7:0] rq[$];
    logic [9:0] txq[$];
    logic [7:0] tf_got[$], rx_got[$];
    int ev_cnt = 0, commit_cnt = 0, abort_cnt = 0, flushed = 0, commit_bad = 0, wr_full_bad = 0;
    logic       ev_last_ok = 1'b0;
    logic [1:0] ev_last_type = 2'b00;
    logic [3:0] ev_last_ep = 4'd0;
    logic       tx_rand = 1'b0, rx_rand = 1'b0;
    logic [1:0] s_reply, s_ev_type;
    logic [3:0] s_cur_ep;
    logic       s_ev_done, s_ev_ok, s_rx_abort, s_rx_commit, s_tx_ready, s_tfifo_wr, s_rx_valid, s_rfifo_rd;

    // Reply expected from the handshake rules, in their stated priority order.
    function automatic logic [1:0] model_reply(input int ep, input int ty, input logic [3:0] st,
                                               input logic [3:0] ir, input logic [3:0] os);
        if (ep >= NEP) return STALL;
        if (ty == 2) return ACK;
        if (st[ep]) return STALL;
        if (ty == 1) return ir[ep] ? ACK : NAK;
        if (ty == 0) return os[ep] ? ACK : NAK;
        return STALL;
    endfunction

    task automatic drive_env();
        rfifo_empty = (rq.size() == 0);
        rfifo_rdata = (rq.size() != 0) ? rq[0] : 8'h00;
        if (txq.size() != 0 && (!tx_rand || ($urandom % 4 != 0))) begin
            tx_valid = 1'b1;
            {tx_zlp, tx_last, tx_data} = txq[0];
        end else begin
            tx_valid = 1'b0; tx_zlp = 1'b0; tx_last = 1'b0; tx_data = 8'h00;
        end
        if (rx_rand) rx_ready = 1'($urandom % 2);
    endtask

    task automatic step();
        logic pop, tacc;
        @(negedge clk);
        s_reply = trsac_reply; s_cur_ep = cur_ep; s_ev_done = ev_done; s_ev_ok = ev_ok;
        s_ev_type = ev_type; s_rx_abort = rx_abort; s_rx_commit = rx_commit; s_tx_ready = tx_ready;
        s_tfifo_wr = tfifo_wr; s_rx_valid = rx_valid; s_rfifo_rd = rfifo_rd;
        if (ev_done) begin
            ev_cnt++; ev_last_ok = ev_ok; ev_last_type = ev_type; ev_last_ep = cur_ep;
        end
        if (rx_commit) begin
            commit_cnt++;
            if (rq.size() != 0 || !(ev_done && ev_ok)) commit_bad++;
        end
        if (rx_abort) abort_cnt++;
        if (tfifo_wr) begin
            tf_got.push_back(tfifo_wdata);
            if (tfifo_full) wr_full_bad++;
        end
        if (rfifo_rd) begin
            if (rx_valid) rx_got.push_back(rx_data);
            else flushed++;
        end
        pop = rfifo_rd;
        tacc = tx_valid && tx_ready;
        @(posedge clk);
        #1;
        if (pop && rq.size() != 0) void'(rq.pop_front());
        if (tacc && txq.size() != 0) void'(txq.pop_front());
        drive_env();
    endtask

    task automatic do_start(input logic [3:0] ep, input logic [1:0] ty);
        trsac_req = R_START; trsac_ep = ep; trsac_type = ty;
        step();
        trsac_req = 2'b00;
        step();
    endtask

    task automatic do_req(input logic [1:0] r);
        trsac_req = r;
        step();
        trsac_req = 2'b00;
    endtask

    task automatic wait_ev(input int base, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (ev_cnt > base) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rq.push_back(8'hA5);
        txq.push_back(10'h011);
        drive_env();
        step(); step();
        checks++;
        if (s_reply !== NAK) begin errors++; $display("FAIL reset_reply got=%b exp=%b", s_reply, NAK); end
        checks++;
        if (s_cur_ep !== 4'd0 || s_ev_type !== 2'd0) begin
            errors++; $display("FAIL reset_ep_type got=%h/%b exp=0/00", s_cur_ep, s_ev_type);
        end
        checks++;
        if ({s_ev_done, s_ev_ok, s_rx_abort, s_rx_commit, s_tx_ready, s_rx_valid, s_rfifo_rd, s_tfifo_wr} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=00000000",
                     {s_ev_done, s_ev_ok, s_rx_abort, s_rx_commit, s_tx_ready, s_rx_valid, s_rfifo_rd, s_tfifo_wr});
        end
        rq.delete(); txq.delete();
        rst = 1'b0;
        drive_env();
        step();
    endtask

    task automatic test_reply_random();
        logic [3:0] ep;
        logic [1:0] ty, exp;
        int base;
        for (int it = 0; it < 30; it++) begin
            ep = ($urandom % 3 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            ty = 2'($urandom % 4);
            ep_stall = 4'($urandom); ep_in_ready = 4'($urandom); ep_out_space = 4'($urandom);
            exp = model_reply(int'(ep), int'(ty), ep_stall, ep_in_ready, ep_out_space);
            base = ev_cnt;
            do_start(ep, ty);
            checks++;
            if (s_reply !== exp || s_cur_ep !== ep) begin
                errors++;
                $display("FAIL rand_reply ep=%0d ty=%0d got=%b/%0d exp=%b/%0d", ep, ty, s_reply, s_cur_ep, exp, ep);
            end
            checks++;
            if (s_ev_done !== (exp != ACK) || (exp != ACK && (s_ev_ok !== 1'b0 || s_ev_type !== ty))) begin
                errors++;
                $display("FAIL rand_ev_n1 ep=%0d ty=%0d got done=%b ok=%b type=%b exp done=%b ok=0 type=%b",
                         ep, ty, s_ev_done, s_ev_ok, s_ev_type, exp != ACK, ty);
            end
            if (exp == ACK) begin
                do_req(R_FAIL);
                wait_ev(base, 8);
            end
            step();
            checks++;
            if (ev_cnt !== base + 1 || ev_last_ok !== 1'b0) begin
                errors++;
                $display("FAIL rand_ev_count ep=%0d ty=%0d got=%0d ok=%b exp=%0d ok=0", ep, ty, ev_cnt - base, ev_last_ok, 1);
            end
        end
    endtask

    task automatic test_nak_stall();
        int rdy_seen = 0;
        ep_stall = '0; ep_in_ready = '0; ep_out_space = '1;
        txq.push_back(10'h055);
        drive_env();
        do_start(4'd2, T_IN);
        checks++;
        if (s_reply !== NAK || s_ev_done !== 1'b1 || s_ev_ok !== 1'b0) begin
            errors++; $display("FAIL in_nak got=%b done=%b ok=%b exp=%b done=1 ok=0", s_reply, s_ev_done, s_ev_ok, NAK);
        end
        for (int i = 0; i < 4; i++) begin
            if (s_tx_ready) rdy_seen++;
            step();
        end
        checks++;
        if (rdy_seen != 0 || txq.size() != 1) begin
            errors++; $display("FAIL nak_tx_ready got=%0d cycles exp=0", rdy_seen);
        end
        ep_stall[2] = 1'b1; ep_in_ready = '1;
        do_start(4'd2, T_IN);
        checks++;
        if (s_reply !== STALL) begin errors++; $display("FAIL in_stall got=%b exp=%b", s_reply, STALL); end
        ep_stall = '0;
        do_start(4'(NEP), T_OUT);
        checks++;
        if (s_reply !== STALL) begin errors++; $display("FAIL ep_unimpl got=%b exp=%b", s_reply, STALL); end
        txq.delete();
        drive_env();
        step();
    endtask

    task automatic test_in_transfer(input logic [3:0] ep, input int n, input bit fixed);
        logic [7:0] exp_b[$];
        int base, bad;
        ep_stall = '0; ep_in_ready = '0; ep_in_ready[ep] = 1'b1;
        tf_got.delete(); tx_rand = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_b.push_back(fixed ? 8'(i) : 8'($urandom));
            txq.push_back({1'b0, (i == n - 1), exp_b[i]});
        end
        drive_env();
        base = ev_cnt;
        do_start(ep, T_IN);
        checks++;
        if (s_reply !== ACK || s_ev_done !== 1'b0) begin
            errors++; $display("FAIL in_ack ep=%0d got=%b done=%b exp=%b done=0", ep, s_reply, s_ev_done, ACK);
        end
        for (int i = 0; i < 100; i++) begin
            if (txq.size() == 0) break;
            step();
        end
        step();
        do_req(R_SUCC);
        wait_ev(base, 6);
        tx_rand = 1'b0;
        bad = (tf_got.size() != n) ? 1 : 0;
        for (int i = 0; i < n && i < tf_got.size(); i++) if (tf_got[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL in_bytes ep=%0d got=%0d bytes (%0d bad) exp=%0d", ep, tf_got.size(), bad, n); end
        checks++;
        if (ev_cnt !== base + 1 || ev_last_ok !== 1'b1 || ev_last_type !== T_IN || ev_last_ep !== ep) begin
            errors++;
            $display("FAIL in_event got n=%0d ok=%b type=%b ep=%0d exp n=1 ok=1 type=01 ep=%0d",
                     ev_cnt - base, ev_last_ok, ev_last_type, ev_last_ep, ep);
        end
    endtask

    task automatic test_tfifo_full();
        logic [7:0] exp_b[$];
        int base, bad = 0, blocked = 0;
        ep_stall = '0; ep_in_ready = 4'b0001;
        tf_got.delete(); wr_full_bad = 0;
        for (int i = 0; i < 12; i++) begin
            exp_b.push_back(8'($urandom));
            txq.push_back({1'b0, (i == 11), exp_b[i]});
        end
        drive_env();
        base = ev_cnt;
        do_start(4'd0, T_IN);
        step(); step();
        tfifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_tx_ready || s_tfifo_wr) blocked++;
        end
        tfifo_full = 1'b0;
        checks++;
        if (blocked != 0 || wr_full_bad != 0) begin
            errors++; $display("FAIL full_block got=%0d active cycles exp=0", blocked + wr_full_bad);
        end
        for (int i = 0; i < 60; i++) begin
            if (txq.size() == 0) break;
            step();
        end
        step();
        do_req(R_SUCC);
        wait_ev(base, 6);
        if (tf_got.size() != 12) bad++;
        for (int i = 0; i < 12 && i < tf_got.size(); i++) if (tf_got[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0 || ev_last_ok !== 1'b1) begin
            errors++; $display("FAIL full_bytes got=%0d bytes ok=%b (%0d bad) exp=12 ok=1", tf_got.size(), ev_last_ok, bad);
        end
    endtask

    task automatic test_zlp();
        int base;
        ep_in_ready = 4'b0010;
        tf_got.delete();
        txq.push_back(10'h300);
        drive_env();
        base = ev_cnt;
        do_start(4'd1, T_IN);
        for (int i = 0; i < 10; i++) begin
            if (txq.size() == 0) break;
            step();
        end
        step();
        do_req(R_SUCC);
        wait_ev(base, 6);
        checks++;
        if (tf_got.size() != 0 || ev_cnt !== base + 1 || ev_last_ok !== 1'b1) begin
            errors++; $display("FAIL zlp got writes=%0d ok=%b exp writes=0 ok=1", tf_got.size(), ev_last_ok);
        end
    endtask

    task automatic test_setup_drain();
        logic [7:0] exp_b[$];
        int base, cbase, bad = 0;
        ep_stall = 4'b0001; ep_out_space = '0;
        rx_got.delete(); commit_bad = 0; cbase = commit_cnt;
        for (int i = 0; i < 8; i++) begin
            exp_b.push_back(8'($urandom));
            rq.push_back(exp_b[i]);
        end
        rx_rand = 1'b1;
        drive_env();
        base = ev_cnt;
        do_start(4'd0, T_SETUP);
        checks++;
        if (s_reply !== ACK) begin errors++; $display("FAIL setup_ack got=%b exp=%b", s_reply, ACK); end
        step(); step();
        do_req(R_SUCC);
        wait_ev(base, 100);
        rx_rand = 1'b0; rx_ready = 1'b0;
        if (rx_got.size() != 8) bad++;
        for (int i = 0; i < 8 && i < rx_got.size(); i++) if (rx_got[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL setup_bytes got=%0d (%0d bad) exp=8", rx_got.size(), bad); end
        checks++;
        if (commit_cnt - cbase != 1 || commit_bad != 0 || ev_last_ok !== 1'b1 || ev_last_type !== T_SETUP) begin
            errors++;
            $display("FAIL setup_commit got commits=%0d early=%0d ok=%b type=%b exp 1/0/1/10",
                     commit_cnt - cbase, commit_bad, ev_last_ok, ev_last_type);
        end
    endtask

    task automatic test_out_fail();
        logic [7:0] exp_b[$];
        int base, abase, cbase;
        ep_stall = '0; ep_out_space = 4'b0010;
        rx_got.delete(); flushed = 0; abase = abort_cnt; cbase = commit_cnt;
        for (int i = 0; i < 5; i++) begin
            exp_b.push_back(8'($urandom));
            rq.push_back(exp_b[i]);
        end
        drive_env();
        base = ev_cnt;
        do_start(4'd1, T_OUT);
        rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rx_got.size() >= 2) break;
            step();
        end
        rx_ready = 1'b0;
        do_req(R_FAIL);
        wait_ev(base, 12);
        checks++;
        if (rx_got.size() != 2 || rx_got[0] !== exp_b[0] || rx_got[1] !== exp_b[1] || flushed != 3) begin
            errors++; $display("FAIL out_fail_bytes got delivered=%0d flushed=%0d exp 2/3", rx_got.size(), flushed);
        end
        checks++;
        if (abort_cnt - abase != 1 || commit_cnt != cbase || ev_last_ok !== 1'b0 || ev_last_type !== T_OUT) begin
            errors++;
            $display("FAIL out_fail_event got aborts=%0d commits=%0d ok=%b type=%b exp 1/0/0/00",
                     abort_cnt - abase, commit_cnt - cbase, ev_last_ok, ev_last_type);
        end
    endtask

    task automatic test_start_during_drain();
        logic [7:0] exp_b[$];
        int base, abase, bad = 0;
        ep_stall = '0; ep_out_space = 4'b0110;
        rx_got.delete();
        for (int i = 0; i < 6; i++) rq.push_back(8'($urandom));
        drive_env();
        do_start(4'd1, T_OUT);
        rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rx_got.size() >= 2) break;
            step();
        end
        rx_ready = 1'b0;
        base = ev_cnt; abase = abort_cnt; flushed = 0;
        do_start(4'd2, T_OUT);
        checks++;
        if (s_reply !== ACK || s_cur_ep !== 4'd2 || s_ev_done !== 1'b1 || s_ev_ok !== 1'b0 ||
            s_ev_type !== T_OUT || s_rx_abort !== 1'b1) begin
            errors++;
            $display("FAIL preempt_n1 got reply=%b ep=%0d done=%b ok=%b type=%b abort=%b exp 00/2/1/0/00/1",
                     s_reply, s_cur_ep, s_ev_done, s_ev_ok, s_ev_type, s_rx_abort);
        end
        for (int i = 0; i < 20; i++) begin
            if (rq.size() == 0) break;
            step();
        end
        step(); step();
        checks++;
        if (flushed != 4) begin errors++; $display("FAIL preempt_flush got=%0d exp=4", flushed); end
        rx_got.delete();
        for (int i = 0; i < 3; i++) begin
            exp_b.push_back(8'($urandom));
            rq.push_back(exp_b[i]);
        end
        rx_ready = 1'b1;
        drive_env();
        step(); step(); step(); step();
        do_req(R_SUCC);
        wait_ev(base + 1, 10);
        rx_ready = 1'b0;
        if (rx_got.size() != 3) bad++;
        for (int i = 0; i < 3 && i < rx_got.size(); i++) if (rx_got[i] !== exp_b[i]) bad++;
        checks++;
        if (bad != 0 || abort_cnt - abase != 1 || ev_cnt !== base + 2 || ev_last_ok !== 1'b1) begin
            errors++;
            $display("FAIL preempt_new got bytes=%0d bad=%0d aborts=%0d events=%0d ok=%b exp 3/0/1/2/1",
                     rx_got.size(), bad, abort_cnt - abase, ev_cnt - base, ev_last_ok);
        end
    endtask

    task automatic test_reset_mid_fill();
        int base, abase;
        ep_stall = '0; ep_in_ready = 4'b1000; tx_rand = 1'b0;
        for (int i = 0; i < 6; i++) txq.push_back({2'b00, 8'($urandom)});
        drive_env();
        do_start(4'd3, T_IN);
        step();
        base = ev_cnt; abase = abort_cnt;
        rst = 1'b1;
        step(); step();
        checks++;
        if (s_reply !== NAK || s_cur_ep !== 4'd0 || s_ev_type !== 2'd0 ||
            {s_ev_done, s_ev_ok, s_rx_abort, s_rx_commit, s_tx_ready, s_rx_valid, s_rfifo_rd, s_tfifo_wr} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_fill got reply=%b ep=%0d type=%b strobes=%b exp 01/0/00/00000000", s_reply, s_cur_ep,
                     s_ev_type, {s_ev_done, s_ev_ok, s_rx_abort, s_rx_commit, s_tx_ready, s_rx_valid, s_rfifo_rd, s_tfifo_wr});
        end
        rst = 1'b0;
        txq.delete();
        drive_env();
        step(); step(); step();
        checks++;
        if (ev_cnt != base || abort_cnt != abase) begin
            errors++; $display("FAIL rst_no_event got events=%0d aborts=%0d exp 0/0", ev_cnt - base, abort_cnt - abase);
        end
    endtask

    initial begin
        drive_env();
        test_reset();
        test_reply_random();
        test_nak_stall();
        test_in_transfer(4'd1, 8, 1'b1);
        test_in_transfer(4'd3, int'($urandom_range(1, 16)), 1'b0);
        test_tfifo_full();
        test_zlp();
        test_setup_drain();
        test_out_fail();
        test_start_during_drain();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
